seq_cla_subtractor: RTL and testbench
=====================================

SEQ_CLA_SUBTRACTOR -- requirements
Module: seq_cla_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; legal values are multiples of 4, minimum 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operands a, b, bin presented.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port a  input  WIDTH  minuend.
REQ-007 SHALL have port b  input  WIDTH  subtrahend.
REQ-008 SHALL have port bin  input  1  borrow-in.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
REQ-012 SHALL have port bout  output  1  borrow-out; 1 when a < b + bin (unsigned).
REQ-013 SHALL have port busy  output  1  high in CALC state.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 SHALL, in IDLE with in_valid=1, capture a, b, bin, clear nibble index, go to CALC; later input changes have no effect.
REQ-017 SHALL compute one 4-bit nibble per CALC cycle, LSB nibble first, as a + ~b + carry via 4-bit carry-lookahead slice; initial carry = ~bin.
REQ-018 SHALL register slice carry-out as carry for next nibble; after nibble WIDTH/4-1 go to DONE.
REQ-019 SHALL set bout = ~(final carry-out).
REQ-020 SHALL give latency exactly WIDTH/4 cycles from accept edge to out_valid=1 (4 cycles for WIDTH=16).
REQ-021 SHALL hold diff, bout, out_valid stable in DONE while out_ready=0 (unbounded backpressure).
REQ-022 SHALL, in DONE with out_ready=1, return to IDLE next edge; in_ready rises that next cycle (no same-cycle accept/deliver).
REQ-023 SHALL ignore in_valid outside IDLE and out_ready outside DONE.
REQ-024 SHALL keep diff and bout at last result in IDLE until the next result completes; partial nibbles never visible while out_valid=0 is acceptable.

Reset
REQ-025 SHALL on rst_n=0, at any state including mid-CALC, immediately force state IDLE, diff=0, bout=0, out_valid=0, busy=0, nibble index=0, carry=0; in_ready=1 after release.
REQ-026 SHALL discard any in-progress operation on reset; no result delivered.

Configuration
REQ-027 SHALL, with macro SUB_OVERFLOW_EN defined, add output ovf (1 bit) = signed two's-complement overflow of a - b - bin, valid with out_valid, reset 0.
REQ-028 SHALL, without SUB_OVERFLOW_EN, have no ovf port and no overflow logic; all other behaviour identical.

Structure
REQ-029 SHALL place FSM state typedef (IDLE/CALC/DONE) and constant NIBBLE_W = 4 in shared package cla_pkg.
REQ-030 SHALL instantiate one combinational sub-module cla4_slice (4-bit a, 4-bit b, cin -> 4-bit sum, cout, generate/propagate lookahead), reused from adder work.

Verification (WIDTH=16)
REQ-031 SHALL cover: a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, out_valid exactly 4 cycles after accept.
REQ-032 SHALL cover: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1; with SUB_OVERFLOW_EN ovf=0.
REQ-033 SHALL cover: a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1; and a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1 when enabled.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles in DONE -> diff/bout/out_valid unchanged, in_ready=0; in_valid pulses during CALC ignored.
REQ-035 SHALL cover: rst_n pulsed low during 2nd CALC cycle -> all outputs 0 asynchronously, no out_valid; next op 0x00FF-0x000F gives diff=0x00F0, bout=0.
REQ-036 SHALL cover: 1000 random back-to-back ops with random out_ready -> every diff/bout matches reference model (a - b - bin) mod 2^16.

Source files
------------

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared FSM state type and nibble width for the sequential CLA subtractor
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla4_slice.sv
// rtl/cla4_slice.sv - combinational 4-bit carry-lookahead adder slice
module cla4_slice
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                cout_o
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] c;
  logic                grp_g;
  logic                grp_p;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Every internal carry is formed directly from g/p and cin, no ripple.
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);

  // Group generate/propagate give the slice carry-out in one lookahead level.
  assign grp_g  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p  = &p;
  assign cout_o = grp_g | (grp_p & cin_i);

  assign sum_o = p ^ c;

endmodule

// File: rtl/seq_cla_subtractor.sv
// rtl/seq_cla_subtractor.sv - nibble-serial a-b-bin subtractor on a CLA slice; optional ovf output under SUB_OVERFLOW_EN
module seq_cla_subtractor
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, b_q, res_q, diff_q;
  logic                 carry_q, bout_q;
  logic [IDX_W-1:0]     idx_q;
  logic [NIBBLE_W-1:0]  sl_sum;
  logic                 sl_cout;
  logic                 last_nib;
  logic [WIDTH-1:0]     res_next;
`ifdef SUB_OVERFLOW_EN
  logic                 ovf_q;
`endif

  // a - b - bin == a + ~b + ~bin; operands are shifted right so slice always sees nibble 0.
  cla4_slice u_slice (
    .a_i    (a_q[NIBBLE_W-1:0]),
    .b_i    (~b_q[NIBBLE_W-1:0]),
    .cin_i  (carry_q),
    .sum_o  (sl_sum),
    .cout_o (sl_cout)
  );

  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));
  // New nibble enters at the top; after the final nibble the word is in order.
  assign res_next = (res_q >> NIBBLE_W) | (WIDTH'(sl_sum) << (WIDTH - NIBBLE_W));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, one nibble per CALC cycle, release on out_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = CALC;
      CALC:    if (last_nib)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == CALC);
  end

  // Datapath: capture operands, step nibbles, publish result only when complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef SUB_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= ~bin;
            idx_q   <= '0;
          end
        end
        CALC: begin
          a_q     <= a_q >> NIBBLE_W;
          b_q     <= b_q >> NIBBLE_W;
          res_q   <= res_next;
          carry_q <= sl_cout;
          idx_q   <= idx_q + IDX_W'(1);
          if (last_nib) begin
            diff_q <= res_next;
            bout_q <= ~sl_cout;
`ifdef SUB_OVERFLOW_EN
            // Operand sign bits are in bit 3 during the top nibble.
            ovf_q  <= (a_q[NIBBLE_W-1] != b_q[NIBBLE_W-1]) && (sl_sum[NIBBLE_W-1] != a_q[NIBBLE_W-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_cla_subtractor.sv
// tb/tb_seq_cla_subtractor.sv - scoreboard bench for seq_cla_subtractor (WIDTH=16)
module tb_seq_cla_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, bout, busy;
  logic [W-1:0] diff;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t vecs[12];

  seq_cla_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .busy      (busy)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake completes on the next rising edge, so sample at the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(diff), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", 32'(diff), 32'(e.d));
        chk("bout", 32'(bout), 32'(e.bo));
`ifdef SUB_OVERFLOW_EN
        chk("ovf", 32'(ovf), 32'(e.ov));
`endif
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       input logic [W-1:0] ed, input logic ebo, input logic eov, input bit push);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      a = ia; b = ib; bin = ibin; in_valid = 1'b1;
      if (push) sb.push_back('{ed, ebo, eov});
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    end
  endtask

  initial begin
    int cnt;
    vecs[0]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2]  = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[4]  = '{16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0};
    vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[8]  = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[9]  = '{16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b0, 1'b0};
    vecs[10] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: out_valid exactly 4 cycles after the accept edge
    out_ready = 1'b1;
    issue(vecs[0].a, vecs[0].b, vecs[0].bin, vecs[0].d, vecs[0].bo, vecs[0].ov, 1'b1);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("in_ready_in_calc", 32'(in_ready), 32'd0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", 32'(cnt), 32'd4);

    // Directed vectors
    for (int i = 1; i < 11; i++)
      issue(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, vecs[i].ov, 1'b1);

    // Backpressure in DONE, in_valid pulses during CALC
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    out_ready = 1'b0;
    issue(vecs[11].a, vecs[11].b, vecs[11].bin, vecs[11].d, vecs[11].bo, vecs[11].ov, 1'b1);
    a = 16'hFFFF; b = 16'h0000; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_diff", 32'(diff), 32'h4B4B);
      chk("hold_bout", 32'(bout), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);

    // Reset during the 2nd CALC cycle discards the operation
    issue(16'h1111, 16'h0001, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_diff", 32'(diff), 32'd0);
    chk("async_rst_bout", 32'(bout), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("no_result_after_rst", 32'(out_valid), 32'd0);
    issue(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b1);

    // Random back-to-back ops against an arithmetic reference, random out_ready
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic         rbin;
      logic [W:0]   full;
      int           s;
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      full = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
      s    = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
      issue(ra, rb, rbin, full[W-1:0], full[W], 1'((s < -32768) || (s > 32767)), 1'b1);
    end
    cnt = 0;
    while (sb.size() != 0 && cnt < 2000) begin
      @(posedge clk); #1;
      cnt++;
    end
    rand_rdy = 1'b0;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
